// File: rtl/theta_isogeny_compute.sv
// rtl/theta_isogeny_compute.sv - theta-coordinate 2-isogeny step: codomain null point and precomputation
// Two cascaded Fp2 multiply stages (Montgomery form, values kept in [0, 2p)).

module theta_fp_mul (
  input  logic         clk,
  input  logic         rst,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic [254:0] r
);
  // REDC with R = 2^256; p = 5*2^248 - 1 gives a sparse -p^-1 mod R.
  localparam logic [511:0] P_W     = (512'd5 << 248) - 512'd1;
  localparam logic [255:0] N_PRIME = (256'd5 << 248) + 256'd1;

  logic [511:0] prod_q;
  logic [511:0] prod_d_q;
  logic [255:0] m_q;
  logic [254:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      prod_d_q <= '0;
      m_q      <= '0;
      r_q      <= '0;
    end else begin
      prod_q   <= 512'(a) * 512'(b);
      prod_d_q <= prod_q;
      m_q      <= 256'(prod_q) * N_PRIME;
      r_q      <= 255'((prod_d_q + 512'(m_q) * P_W) >> 256);
    end
  end

  assign r = r_q;
endmodule

module theta_fp2_mul (
  input  logic         clk,
  input  logic         rst,
  input  logic [254:0] a_re,
  input  logic [254:0] a_im,
  input  logic [254:0] b_re,
  input  logic [254:0] b_im,
  output logic [254:0] c_re,
  output logic [254:0] c_im
);
  localparam logic [255:0] P2 = (256'd10 << 248) - 256'd2;

  // Add/sub keep results in [0, 2p) by folding with 2p rather than p.
  function automatic logic [254:0] add_mod(input logic [254:0] x, input logic [254:0] y);
    logic [255:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= P2) s = s - P2;
    return 255'(s);
  endfunction

  function automatic logic [254:0] sub_mod(input logic [254:0] x, input logic [254:0] y);
    logic [255:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + P2;
    return 255'(d);
  endfunction

  logic [254:0] a0_q, a1_q, b0_q, b1_q, sa_q, sb_q;
  logic [254:0] u0, u1, u2;
  logic [254:0] re_q, mid_q, u1_q, c_re_q, c_im_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0_q   <= '0;
      a1_q   <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      sa_q   <= '0;
      sb_q   <= '0;
      re_q   <= '0;
      mid_q  <= '0;
      u1_q   <= '0;
      c_re_q <= '0;
      c_im_q <= '0;
    end else begin
      a0_q   <= a_re;
      a1_q   <= a_im;
      b0_q   <= b_re;
      b1_q   <= b_im;
      sa_q   <= add_mod(a_re, a_im);
      sb_q   <= add_mod(b_re, b_im);
      re_q   <= sub_mod(u0, u1);
      mid_q  <= sub_mod(u2, u0);
      u1_q   <= u1;
      c_re_q <= re_q;
      c_im_q <= sub_mod(mid_q, u1_q);
    end
  end

  theta_fp_mul u_mul0 (.clk(clk), .rst(rst), .a(a0_q), .b(b0_q), .r(u0));
  theta_fp_mul u_mul1 (.clk(clk), .rst(rst), .a(a1_q), .b(b1_q), .r(u1));
  theta_fp_mul u_mul2 (.clk(clk), .rst(rst), .a(sa_q), .b(sb_q), .r(u2));

  assign c_re = c_re_q;
  assign c_im = c_im_q;
endmodule

module theta_isogeny_compute (
  input  logic         clk,
  input  logic         rst,
  input  logic [254:0] TT1_A1,
  input  logic [254:0] TT1_A2,
  input  logic [254:0] TT1_A3,
  input  logic [254:0] TT1_A4,
  input  logic [254:0] TT1_B1,
  input  logic [254:0] TT1_B2,
  input  logic [254:0] TT1_B3,
  input  logic [254:0] TT1_B4,
  input  logic [254:0] TT2_A1,
  input  logic [254:0] TT2_A2,
  input  logic [254:0] TT2_A3,
  input  logic [254:0] TT2_A4,
  input  logic [254:0] TT2_B1,
  input  logic [254:0] TT2_B2,
  input  logic [254:0] TT2_B3,
  input  logic [254:0] TT2_B4,
  output logic [254:0] PRECOMP_D1_re,
  output logic [254:0] PRECOMP_D1_im,
  output logic [254:0] PRECOMP_D2_re,
  output logic [254:0] PRECOMP_D2_im,
  output logic [254:0] PRECOMP_D3_re,
  output logic [254:0] PRECOMP_D3_im,
  output logic [254:0] PRECOMP_D4_re,
  output logic [254:0] PRECOMP_D4_im,
  output logic [254:0] NULL_POINT_D1_re,
  output logic [254:0] NULL_POINT_D1_im,
  output logic [254:0] NULL_POINT_D2_re,
  output logic [254:0] NULL_POINT_D2_im,
  output logic [254:0] NULL_POINT_D3_re,
  output logic [254:0] NULL_POINT_D3_im,
  output logic [254:0] NULL_POINT_D4_re,
  output logic [254:0] NULL_POINT_D4_im
);
  localparam int LATENCY_FP2_MUL = 6;
  localparam int LATENCY_THETA_ISOGENY_COMPUTE = 2 * LATENCY_FP2_MUL;
  localparam int DELAY_DEPTH = LATENCY_THETA_ISOGENY_COMPUTE - LATENCY_FP2_MUL;

  typedef struct packed {
    logic [254:0] im;
    logic [254:0] re;
  } fp2_t;

  fp2_t x1, y1, z1, t1, x2, y2, z2, t2;
  fp2_t [13:0] opa;
  fp2_t [13:0] opb;
  fp2_t [13:0] res;
  fp2_t [5:0]  dly_q [DELAY_DEPTH];
  fp2_t [5:0]  dly;

  assign x1 = {TT1_B1, TT1_A1};
  assign y1 = {TT1_B2, TT1_A2};
  assign z1 = {TT1_B3, TT1_A3};
  assign t1 = {TT1_B4, TT1_A4};
  assign x2 = {TT2_B1, TT2_A1};
  assign y2 = {TT2_B2, TT2_A2};
  assign z2 = {TT2_B3, TT2_A3};
  assign t2 = {TT2_B4, TT2_A4};

  // Stage-2 operands taken straight from the inputs ride this line to meet t1..t6.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DELAY_DEPTH; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {t2, z2, y2, x2, y1, x1};
      for (int i = 1; i < DELAY_DEPTH; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign dly = dly_q[DELAY_DEPTH-1];

  assign opa[0]  = x1;      assign opb[0]  = x2;
  assign opa[1]  = y1;      assign opb[1]  = y2;
  assign opa[2]  = z2;      assign opb[2]  = t2;
  assign opa[3]  = x1;      assign opb[3]  = y2;
  assign opa[4]  = y1;      assign opb[4]  = x2;
  assign opa[5]  = z1;      assign opb[5]  = t1;
  assign opa[6]  = dly[2];  assign opb[6]  = res[1];
  assign opa[7]  = dly[3];  assign opb[7]  = res[0];
  assign opa[8]  = dly[4];  assign opb[8]  = res[4];
  assign opa[9]  = dly[5];  assign opb[9]  = res[3];
  assign opa[10] = res[2];  assign opb[10] = dly[1];
  assign opa[11] = res[2];  assign opb[11] = dly[0];
  assign opa[12] = res[5];  assign opb[12] = dly[5];
  assign opa[13] = res[5];  assign opb[13] = dly[4];

  for (genvar g = 0; g < 14; g++) begin : g_mul
    theta_fp2_mul u_fp2_mul (
      .clk (clk),
      .rst (rst),
      .a_re(opa[g].re),
      .a_im(opa[g].im),
      .b_re(opb[g].re),
      .b_im(opb[g].im),
      .c_re(res[g].re),
      .c_im(res[g].im)
    );
  end

  assign NULL_POINT_D1_re = res[6].re;
  assign NULL_POINT_D1_im = res[6].im;
  assign NULL_POINT_D2_re = res[7].re;
  assign NULL_POINT_D2_im = res[7].im;
  assign NULL_POINT_D3_re = res[8].re;
  assign NULL_POINT_D3_im = res[8].im;
  assign NULL_POINT_D4_re = res[9].re;
  assign NULL_POINT_D4_im = res[9].im;
  assign PRECOMP_D1_re    = res[10].re;
  assign PRECOMP_D1_im    = res[10].im;
  assign PRECOMP_D2_re    = res[11].re;
  assign PRECOMP_D2_im    = res[11].im;
  assign PRECOMP_D3_re    = res[12].re;
  assign PRECOMP_D3_im    = res[12].im;
  assign PRECOMP_D4_re    = res[13].re;
  assign PRECOMP_D4_im    = res[13].im;
endmodule

// File: tb/tb_theta_isogeny_compute.sv
// tb/tb_theta_isogeny_compute.sv - table-driven and randomized bench for theta_isogeny_compute
// Reference model works on whole field elements with wide integer arithmetic.

module tb_theta_isogeny_compute;
  localparam int LAT   = 12;
  localparam int DEPTH = 512;
  localparam logic [511:0] PW  = (512'd5 << 248) - 512'd1;
  localparam logic [511:0] P2W = PW << 1;
  localparam logic [511:0] RW  = 512'd1 << 256;
  localparam logic [511:0] NPW = (512'd5 << 248) + 512'd1;

  typedef logic [15:0][254:0] fv_t;
  typedef logic [1:0][254:0]  f2_t;
  typedef struct {
    fv_t din;
    fv_t dexp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  fv_t  din;
  wire [15:0][254:0] dout;

  fv_t hist     [DEPTH];
  bit  rst_hist [DEPTH];
  int  e = 0;
  int  checks = 0;
  int  failures = 0;
  logic [254:0] m1, m2, m4, p_val;
  vec_t tbl [5];

  always #5 clk = ~clk;

  theta_isogeny_compute dut (
    .clk(clk), .rst(rst),
    .TT1_A1(din[0]),  .TT1_A2(din[1]),  .TT1_A3(din[2]),  .TT1_A4(din[3]),
    .TT1_B1(din[4]),  .TT1_B2(din[5]),  .TT1_B3(din[6]),  .TT1_B4(din[7]),
    .TT2_A1(din[8]),  .TT2_A2(din[9]),  .TT2_A3(din[10]), .TT2_A4(din[11]),
    .TT2_B1(din[12]), .TT2_B2(din[13]), .TT2_B3(din[14]), .TT2_B4(din[15]),
    .NULL_POINT_D1_re(dout[0]), .NULL_POINT_D2_re(dout[1]),
    .NULL_POINT_D3_re(dout[2]), .NULL_POINT_D4_re(dout[3]),
    .NULL_POINT_D1_im(dout[4]), .NULL_POINT_D2_im(dout[5]),
    .NULL_POINT_D3_im(dout[6]), .NULL_POINT_D4_im(dout[7]),
    .PRECOMP_D1_re(dout[8]),    .PRECOMP_D2_re(dout[9]),
    .PRECOMP_D3_re(dout[10]),   .PRECOMP_D4_re(dout[11]),
    .PRECOMP_D1_im(dout[12]),   .PRECOMP_D2_im(dout[13]),
    .PRECOMP_D3_im(dout[14]),   .PRECOMP_D4_im(dout[15])
  );

  function automatic logic [254:0] mm(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] t, m;
    t = 512'(a) * 512'(b);
    m = ((t % RW) * NPW) % RW;
    return 255'((t + m * PW) / RW);
  endfunction

  function automatic logic [254:0] addm(input logic [254:0] x, input logic [254:0] y);
    return 255'((512'(x) + 512'(y)) % P2W);
  endfunction

  function automatic logic [254:0] subm(input logic [254:0] x, input logic [254:0] y);
    return 255'((512'(x) + P2W - 512'(y)) % P2W);
  endfunction

  function automatic logic [254:0] to_mont(input int unsigned k);
    return 255'((512'(k) * RW) % PW);
  endfunction

  function automatic f2_t fmul(input f2_t a, input f2_t b);
    f2_t r;
    logic [254:0] r0, r1, rs;
    r0 = mm(a[0], b[0]);
    r1 = mm(a[1], b[1]);
    rs = mm(addm(a[0], a[1]), addm(b[0], b[1]));
    r[0] = subm(r0, r1);
    r[1] = subm(subm(rs, r0), r1);
    return r;
  endfunction

  function automatic fv_t model(input fv_t v);
    fv_t o;
    f2_t x1, y1, z1, w1, x2, y2, z2, w2, t1, t2, t3, t4, t5, t6;
    f2_t n [4];
    f2_t pc [4];
    x1 = {v[4], v[0]};   y1 = {v[5], v[1]};   z1 = {v[6], v[2]};   w1 = {v[7], v[3]};
    x2 = {v[12], v[8]};  y2 = {v[13], v[9]};  z2 = {v[14], v[10]}; w2 = {v[15], v[11]};
    t1 = fmul(x1, x2);  t2 = fmul(y1, y2);  t3 = fmul(z2, w2);
    t4 = fmul(x1, y2);  t5 = fmul(y1, x2);  t6 = fmul(z1, w1);
    n[0] = fmul(x2, t2);  n[1] = fmul(y2, t1);  n[2] = fmul(z2, t5);  n[3] = fmul(w2, t4);
    pc[0] = fmul(t3, y1); pc[1] = fmul(t3, x1); pc[2] = fmul(t6, w2); pc[3] = fmul(t6, z2);
    for (int k = 0; k < 4; k++) begin
      o[k]      = n[k][0];
      o[4 + k]  = n[k][1];
      o[8 + k]  = pc[k][0];
      o[12 + k] = pc[k][1];
    end
    return o;
  endfunction

  function automatic fv_t rnd_fv();
    fv_t v;
    logic [255:0] r;
    for (int k = 0; k < 16; k++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      v[k] = 255'(512'(r) % P2W);
    end
    return v;
  endfunction

  task automatic compare();
    fv_t want;
    bit live;
    int bad;
    live = (e > LAT - 1);
    if (live)
      for (int j = e - (LAT - 1); j <= e; j++)
        if (!rst_hist[j]) live = 0;
    want = live ? hist[e - (LAT - 1)] : '0;
    checks++;
    if (dout !== want) begin
      failures++;
      bad = 0;
      for (int k = 15; k >= 0; k--)
        if (dout[k] !== want[k]) bad = k;
      $display("FAIL out_edge%0d idx=%0d got=%h want=%h", e, bad, dout[bad], want[bad]);
    end
  endtask

  task automatic cycle(input fv_t v, input fv_t ex);
    din = v;
    @(posedge clk);
    #1;
    if (e < DEPTH - 1) e++;
    rst_hist[e] = rst;
    hist[e] = rst ? ex : '0;
    compare();
  endtask

  task automatic reset_pulse();
    fv_t v;
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== '0) begin
      failures++;
      $display("FAIL async_flush got=%h want=0", dout[0]);
    end
    v = rnd_fv();
    cycle(v, model(v));
    rst = 1'b1;
  endtask

  initial begin
    fv_t v;
    rst = 1'b0;
    din = '0;
    m1 = to_mont(1);
    m2 = to_mont(2);
    m4 = to_mont(4);
    p_val = 255'(PW);

    tbl[0].din = '0;
    tbl[0].dexp = '0;
    for (int k = 0; k < 4; k++) begin
      tbl[0].din[k] = m1;
      tbl[0].din[8 + k] = m1;
      tbl[0].dexp[k] = m1;
      tbl[0].dexp[8 + k] = m1;
    end
    tbl[1].din = '0;
    tbl[1].dexp = '0;
    tbl[2] = tbl[0];
    tbl[2].din[0] = m2;
    tbl[2].din[8] = m2;
    tbl[2].dexp[0] = m2;  tbl[2].dexp[1] = m4;  tbl[2].dexp[2] = m2;  tbl[2].dexp[3] = m2;
    tbl[2].dexp[8] = m1;  tbl[2].dexp[9] = m2;  tbl[2].dexp[10] = m1; tbl[2].dexp[11] = m1;
    tbl[3].din = '0;
    for (int k = 0; k < 4; k++) begin
      tbl[3].din[k] = m1 + p_val;
      tbl[3].din[8 + k] = m1 + p_val;
      tbl[3].din[12 + k] = p_val;
    end
    tbl[3].dexp = model(tbl[3].din);
    tbl[4].din = rnd_fv();
    tbl[4].dexp = model(tbl[4].din);

    for (int i = 0; i < 3; i++) cycle(rnd_fv(), '0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) cycle(tbl[i].din, tbl[i].dexp);
    for (int i = 0; i < LAT; i++) cycle('0, '0);

    for (int i = 0; i < 30; i++) begin
      v = rnd_fv();
      cycle(v, model(v));
    end
    reset_pulse();
    for (int i = 0; i < 30; i++) begin
      v = rnd_fv();
      cycle(v, model(v));
    end
    for (int i = 0; i < LAT; i++) cycle('0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
